// File: rtl/stream_cipher_pkg.sv
// stream_cipher_pkg: shared types and defaults for the stream cipher pin interface blocks.
package stream_cipher_pkg;
  typedef enum logic [1:0] {IF_IDLE, IF_LOAD, IF_RUN} interface_state_t;
  typedef enum logic [1:0] {OH_IDLE, OH_PRESENT, OH_WAIT_REL} output_holder_state_t;
  typedef enum logic [1:0] {IDLE, WAIT_SPACE, ACK} input_holder_state_t;
  localparam int INPUT_HOLDER_DEPTH = 2;
  localparam int INPUT_HOLDER_SYNC_STAGES = 2;
endpackage

// File: rtl/input_holder_pin_sync.sv
// pin_sync: flop-chain synchroniser for an asynchronous pin with a registered rising-edge pulse.
module pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);
  logic [STAGES-1:0] chain;
  logic prev;
  assign level = chain[STAGES-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= level;
      rise  <= level & ~prev;
    end
endmodule

// File: rtl/input_holder.sv
// input_holder: four-phase pin handshake capture into a small FIFO for the cipher core,
// plus the synchronised output-acknowledge release pulse.
module input_holder import stream_cipher_pkg::*; #(
  parameter int DEPTH = INPUT_HOLDER_DEPTH,
  parameter int SYNC_STAGES = INPUT_HOLDER_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          data_in,
  input  logic                input_valid,
  input  logic                output_acknowledge,
  output logic                input_acknowledged,
  output logic [7:0]          core_data,
  output logic                core_valid,
  input  logic                core_ready,
  output logic                output_consumed,
  output input_holder_state_t input_holder_state
);
  localparam int AW = $clog2(DEPTH);
  input_holder_state_t state_q, state_d;
  logic [7:0] mem [DEPTH];
  logic [7:0] last_q;
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic vld_s, vld_rise, oack_level, unused_sync;
  logic push, pop, can_push;
  pin_sync #(.STAGES(SYNC_STAGES)) u_vld_sync (
    .clk, .rst_n, .async_in(input_valid), .level(vld_s), .rise(vld_rise)
  );
  pin_sync #(.STAGES(SYNC_STAGES)) u_oack_sync (
    .clk, .rst_n, .async_in(output_acknowledge), .level(oack_level), .rise(output_consumed)
  );
  assign unused_sync = vld_rise ^ oack_level;
  assign core_valid = count != '0;
  assign pop = core_valid && core_ready;
  assign can_push = count < (AW+1)'(DEPTH) || pop;
  assign core_data = core_valid ? mem[head] : last_q;
  assign input_holder_state = state_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // vld_s can only be high in IDLE right after it rises: ACK is left only once it is low
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = vld_s ? (can_push ? ACK : WAIT_SPACE) : IDLE;
      WAIT_SPACE: state_d = can_push ? ACK : WAIT_SPACE;
      ACK:        state_d = vld_s ? ACK : IDLE;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    push = can_push && (state_q == WAIT_SPACE || (state_q == IDLE && vld_s));
    input_acknowledged = state_q == ACK;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      last_q <= 8'h00;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop) begin
        head   <= head + AW'(1);
        last_q <= mem[head];
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[tail] <= data_in;
endmodule

// File: doc/input_holder.md
# input_holder

Captures bytes that the chip user presents on the input pins with a four-phase valid/acknowledge handshake and queues them for the stream cipher core. It is the receive-side counterpart of the output path, and drives the `input_acknowledged` pin. It also synchronises the user's `output_acknowledge` pin into a single-cycle release pulse for the output holder. The block sits between the chip pins and the cipher core, beside the output holder and output mux.

## Interface
- `DEPTH`, 2, number of FIFO entries; must be a power of two and at least 2.
- `SYNC_STAGES`, 2, number of synchroniser flops on each asynchronous pin input; must be at least 2.

- `clk` in 1: single clock; all state is updated on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_in` in 8: user byte. It must be stable from before `input_valid` rises until `input_acknowledged` is high.
- `input_valid` in 1: user request pin; asynchronous to `clk`.
- `output_acknowledge` in 1: user "output read" pin; asynchronous to `clk`.
- `input_acknowledged` out 1: handshake acknowledge pin; registered.
- `core_data` out 8: FIFO head byte.
- `core_valid` out 1: FIFO not empty.
- `core_ready` in 1: core accepts the head byte when `core_valid && core_ready`.
- `output_consumed` out 1: one-cycle pulse that releases the output holder.
- `input_holder_state` out `input_holder_state_t`: current FSM state.

## Operation
- Each asynchronous pin passes through a `SYNC_STAGES` flop chain, then an edge-detect register.
  - Synchroniser and edge registers reset to 0.
  - `vld_s` is the synchronised `input_valid`.
- FSM states:
  - `IDLE`:
    - On `vld_s` rising: if the FIFO is not full, push `data_in` and go to `ACK`.
    - If the FIFO is full, go to `WAIT_SPACE`.
  - `WAIT_SPACE`: push `data_in` and go to `ACK` as soon as a push is permitted.
  - `ACK`:
    - `input_acknowledged` = 1.
    - When `vld_s` is 0, go to `IDLE`; `input_acknowledged` falls on that edge.
- Push permitted: `count < DEPTH`, or a pop occurs in the same cycle. A simultaneous push and pop when full leaves `count` unchanged.
- Pop: `core_valid && core_ready`. The head pointer advances by one.
- FIFO pointers:
  - Pointers are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH`.
  - `count` is `$clog2(DEPTH)+1` bits wide.
  - `core_data` is driven combinationally from the head entry. When the FIFO is empty, `core_data` holds its last value and the core must ignore it.
- A push while empty does not make `core_valid` high until the next cycle. There is no bypass path.
- `output_consumed` = 1 for exactly one cycle on each synchronised rising edge of `output_acknowledge`. It is independent of the FSM.
- Only one byte is captured per `input_valid` high pulse. `input_valid` glitches that are shorter than one clock may be missed; this is permitted.

## Timing
- Reset values:
  - State = `IDLE`, FIFO empty.
  - `input_acknowledged` = 0, `core_valid` = 0, `output_consumed` = 0.
  - `core_data` = 0x00.
- Input capture latency: let edge 1 be the first edge that samples `input_valid` high. The push and `input_acknowledged` = 1 both happen at edge `SYNC_STAGES+1` (edge 3 by default).
- `core_valid` goes high one edge later.
- Acknowledge release: `input_acknowledged` falls at edge `SYNC_STAGES+1` counted from the first edge that samples `input_valid` low.
- `output_consumed` latency: the pulse is high in the cycle after edge `SYNC_STAGES+1` counted from the first edge that samples `output_acknowledge` high.
- Reset mid-operation:
  - Reset immediately clears the FIFO, the FSM and the acknowledge.
  - If `input_valid` is still high after reset, it is treated as a new rising edge and the byte is captured again. The user must drop `input_valid` before releasing reset.
- Full-FIFO case: `input_acknowledged` is withheld until there is space. The user keeps `input_valid` and `data_in` stable until then.

## Structure
- Shared `stream_cipher_pkg` holds:
  - `input_holder_state_t` (`IDLE`, `WAIT_SPACE`, `ACK`), alongside the existing `interface_state_t` and `output_holder_state_t`.
  - Default constants for `DEPTH` and `SYNC_STAGES`.
- Sub-module `pin_sync`: a parameterised `SYNC_STAGES` flop chain with asynchronous active-low reset and a registered rising-edge pulse output. It is instantiated twice, once for `input_valid` and once for `output_acknowledge`.
- The FIFO stays inline in `input_holder`.

## Test plan
- Reset, then a single byte with `core_ready` = 1:
  - `data_in` = 0xA5, `input_valid` high at edge 1.
  - `input_acknowledged` = 1 at edge 3; `core_valid` = 1 with `core_data` = 0xA5 at edge 4.
  - The pop empties the FIFO.
- Drop `input_valid` at edge 10 → `input_acknowledged` = 0 at edge 12. A second byte 0x3C is then captured exactly once.
- `core_ready` = 0 and three bytes sent (0x01, 0x02, 0x03):
  - The first two are acknowledged.
  - The third waits in `WAIT_SPACE` with `input_acknowledged` = 0.
  - Raise `core_ready` → the core receives 0x01, the third byte is acknowledged, and the order out is 0x01, 0x02, 0x03.
- Full FIFO with a simultaneous pop and push in the same cycle: `count` stays 2 and no data is lost or duplicated.
- Pulse `output_acknowledge` high for 5 cycles → exactly one `output_consumed` pulse, 3 edges after the first sample.
- Assert `rst_n` low while in `ACK` with the FIFO holding 1 byte:
  - Immediately `input_acknowledged` = 0 and `core_valid` = 0.
  - After release with `input_valid` held high, a recapture occurs at edge 3.
